// File: rtl/dac_pacer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dac_pacer_pkg
// Brief    : Shared types, defaults and parity helpers for the DAC sample pacer.
// Revision : 1.0
// ============================================================================
package dac_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pacer_state_t;

    localparam int unsigned c_WARMUP_CYCLES_DEFAULT = 1024;

    function automatic logic [3:0] byte_parities(input logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    function automatic logic even_parity32(input logic [31:0] d);
        return ^byte_parities(d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_pipe_2stage.sv
`default_nettype none
// ============================================================================
// Module   : parity_pipe_2stage
// Brief    : Two-stage sample register with even parity (byte parities, then fold).
// Revision : 1.0
// ============================================================================
module parity_pipe_2stage
    import dac_pacer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data,
    input  logic        i_vld,
    output logic [31:0] o_data,
    output logic        o_parity,
    output logic        o_vld
);

    logic [31:0] r_s1_data;
    logic [3:0]  r_s1_bpar;
    logic        r_s1_vld;
    logic [31:0] r_s2_data;
    logic        r_s2_par;
    logic        r_s2_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_data <= '0;
            r_s1_bpar <= '0;
            r_s1_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_par  <= 1'b0;
            r_s2_vld  <= 1'b0;
        end else begin
            r_s1_vld <= i_vld;
            // Stage 1 holds the last sample between reads so the output stays stable.
            if (i_vld) begin
                r_s1_data <= i_data;
                r_s1_bpar <= byte_parities(i_data);
            end
            r_s2_data <= r_s1_data;
            r_s2_par  <= ^r_s1_bpar;
            r_s2_vld  <= r_s1_vld;
        end
    end

    assign o_data   = r_s2_data;
    assign o_parity = r_s2_par;
    assign o_vld    = r_s2_vld;

endmodule
`default_nettype wire

// File: rtl/dac_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_pacer
// Brief    : Paces FWFT DAC sample reads at a programmable rate, adds parity, keeps status.
// Revision : 1.0
// ============================================================================
module dac_sample_pacer
    import dac_pacer_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = c_WARMUP_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_srst,
    input  logic             i_enable,
    input  logic [15:0]      i_rate_div,
    output logic             o_dac_data_rd,
    input  logic [31:0]      i_dac_data,
    input  logic             i_dac_fifo_underflow,
    output logic [31:0]      o_dac_sample,
    output logic             o_dac_sample_parity,
    output logic             o_dac_sample_vld,
    output logic [CNT_W-1:0] o_underflow_cnt,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic             o_running
);

    // A zero warmup still spends one clock in WARMUP.
    localparam int unsigned      c_WU_EFF  = (WARMUP_CYCLES == 0) ? 1 : WARMUP_CYCLES;
    localparam int unsigned      c_WU_W    = (c_WU_EFF > 1) ? $clog2(c_WU_EFF) : 1;
    localparam logic [c_WU_W-1:0] c_WU_LAST = c_WU_W'(c_WU_EFF - 1);

    pacer_state_t      r_state;
    pacer_state_t      w_state_nxt;
    logic [c_WU_W-1:0] r_wu_cnt;
    logic [15:0]       r_rate_cnt;
    logic [15:0]       r_rate_div;
    logic              r_was_run;
    logic [CNT_W-1:0]  r_uf_cnt;
    logic [CNT_W-1:0]  r_smp_cnt;
    logic              w_rd;
    logic              w_pipe_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_enable) w_state_nxt = WARMUP;
            WARMUP: begin
                if (!i_enable)                  w_state_nxt = IDLE;
                else if (r_wu_cnt == c_WU_LAST) w_state_nxt = RUN;
            end
            RUN:     if (!i_enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd = (r_state == RUN) && (r_rate_cnt == 16'd0);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_srst) begin
            r_state    <= IDLE;
            r_wu_cnt   <= '0;
            r_rate_cnt <= '0;
            r_rate_div <= '0;
            r_was_run  <= 1'b0;
            r_uf_cnt   <= '0;
            r_smp_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_was_run <= (r_state == RUN);

            if (r_state == WARMUP) r_wu_cnt <= r_wu_cnt + c_WU_W'(1);
            else                   r_wu_cnt <= '0;

            // Outside RUN the divider tracks the input so RUN entry starts from a fresh latch.
            if (r_state != RUN || r_rate_cnt == r_rate_div) begin
                r_rate_cnt <= 16'd0;
                r_rate_div <= i_rate_div;
            end else begin
                r_rate_cnt <= r_rate_cnt + 16'd1;
            end

            if (i_dac_fifo_underflow && (r_state == RUN || r_was_run) &&
                r_uf_cnt != {CNT_W{1'b1}})
                r_uf_cnt <= r_uf_cnt + CNT_W'(1);

            if (w_pipe_vld) r_smp_cnt <= r_smp_cnt + CNT_W'(1);
        end
    end

    parity_pipe_2stage u_pipe (
        .i_clk    (i_sys_clk),
        .i_rst    (i_sys_srst),
        .i_data   (i_dac_data),
        .i_vld    (w_rd),
        .o_data   (o_dac_sample),
        .o_parity (o_dac_sample_parity),
        .o_vld    (w_pipe_vld)
    );

    assign o_dac_data_rd    = w_rd;
    assign o_dac_sample_vld = w_pipe_vld;
    assign o_underflow_cnt  = r_uf_cnt;
    assign o_sample_cnt     = r_smp_cnt;
    assign o_running        = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_pacer
// Brief    : Self-checking bench: vector table, directed corner cases, random vs model.
// Revision : 1.0
// ============================================================================
module tb_dac_sample_pacer;

    localparam int WU = 8;
    localparam int CW = 4;

    logic          clk;
    logic          srst;
    logic          en;
    logic [15:0]   rate_div;
    logic          rd;
    logic [31:0]   dac_data;
    logic          uf;
    logic [31:0]   sample;
    logic          par;
    logic          vld;
    logic [CW-1:0] uf_cnt;
    logic [CW-1:0] smp_cnt;
    logic          running;

    dac_sample_pacer #(.WARMUP_CYCLES(WU), .CNT_W(CW)) dut (
        .i_sys_clk            (clk),
        .i_sys_srst           (srst),
        .i_enable             (en),
        .i_rate_div           (rate_div),
        .o_dac_data_rd        (rd),
        .i_dac_data           (dac_data),
        .i_dac_fifo_underflow (uf),
        .o_dac_sample         (sample),
        .o_dac_sample_parity  (par),
        .o_dac_sample_vld     (vld),
        .o_underflow_cnt      (uf_cnt),
        .o_sample_cnt         (smp_cnt),
        .o_running            (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] data; } pend_t;
    typedef struct { logic [31:0] data; logic par; } vec_t;

    pend_t q[$];
    vec_t  tbl [5];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: mode 0 idle, 1 warmup, 2 run; reads scheduled by absolute cycle.
    int m_mode = 0;
    int m_next_read = 0;
    int m_div = 0;
    int m_run_at = 0;
    int m_uf = 0;
    int m_smp = 0;
    bit m_prev_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_advance();
        bit    rd_now;
        bit    vld_now;
        pend_t p;
        rd_now  = (m_mode == 2) && (cyc == m_next_read);
        vld_now = (q.size() > 0) && (q[0].due == cyc);
        if (srst) begin
            q.delete();
            m_mode = 0; m_uf = 0; m_smp = 0; m_prev_run = 0;
            cyc++;
            return;
        end
        if (rd_now) begin
            p.due  = cyc + 2;
            p.data = dac_data;
            q.push_back(p);
            m_next_read = cyc + m_div + 1;
        end
        if (m_mode == 2 && cyc == m_next_read - 1) m_div = int'(rate_div);
        if (vld_now) begin
            void'(q.pop_front());
            m_smp = (m_smp + 1) % (1 << CW);
        end
        if (uf && (m_mode == 2 || m_prev_run) && m_uf < (1 << CW) - 1) m_uf++;
        m_prev_run = (m_mode == 2);
        case (m_mode)
            0: if (en) begin m_mode = 1; m_run_at = cyc + 1 + WU; end
            1: begin
                if (!en) m_mode = 0;
                else if (cyc + 1 == m_run_at) begin
                    m_mode = 2; m_next_read = cyc + 1; m_div = int'(rate_div);
                end
            end
            default: if (!en) m_mode = 0;
        endcase
        cyc++;
    endtask

    task automatic compare_now();
        bit e_rd;
        bit e_vld;
        e_rd  = (m_mode == 2) && (cyc == m_next_read);
        e_vld = (q.size() > 0) && (q[0].due == cyc);
        check("rd", 32'(rd), 32'(e_rd));
        check("vld", 32'(vld), 32'(e_vld));
        if (e_vld) begin
            check("sample", sample, q[0].data);
            check("parity", 32'(par), 32'(^q[0].data));
        end
        check("running", 32'(running), 32'(m_mode == 2));
        check("uf_cnt", 32'(uf_cnt), 32'(m_uf));
        check("smp_cnt", 32'(smp_cnt), 32'(m_smp));
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        compare_now();
    endtask

    task automatic wait_rd();
        for (int i = 0; i < 40 && !rd; i++) step();
        check("wait_rd", 32'(rd), 32'd1);
    endtask

    task automatic wait_running();
        for (int i = 0; i < 40 && !running; i++) step();
        check("wait_running", 32'(running), 32'd1);
    endtask

    initial begin
        int k;
        srst = 1'b1; en = 1'b0; rate_div = 16'd0; dac_data = 32'd0; uf = 1'b0;
        tbl[0] = '{32'h0000_0000, 1'b0};
        tbl[1] = '{32'h0000_0001, 1'b1};
        tbl[2] = '{32'hFFFF_FFFF, 1'b0};
        tbl[3] = '{32'h8000_0001, 1'b0};
        tbl[4] = '{32'h1234_5678, 1'b1};

        // Reset state
        step(); step();
        check("rst_sample", sample, 32'd0);
        check("rst_parity", 32'(par), 32'd0);
        srst = 1'b0;
        step(); step();

        // Warmup timing, read period 4, vld latency 2
        rate_div = 16'd3; en = 1'b1;
        k = 0;
        do begin step(); k++; end while (!running && k < 40);
        check("warmup_delay", 32'(k), 32'(WU + 1));
        check("first_rd", 32'(rd), 32'd1);
        step(); step();
        check("vld_latency", 32'(vld), 32'd1);
        step(); step();
        check("rd_period4", 32'(rd), 32'd1);

        // Rate change 3 -> 0 mid-period: current period still 4 clocks
        step();
        rate_div = 16'd0;
        step(); step();
        check("rd_mid_period", 32'(rd), 32'd0);
        step();
        check("rd_old_period_end", 32'(rd), 32'd1);
        step();
        check("rd_every_clock", 32'(rd), 32'd1);

        // Parity vectors on back-to-back reads
        for (int i = 0; i < 6; i++) begin
            dac_data = (i < 5) ? tbl[i].data : 32'd0;
            step();
            if (i >= 1) begin
                check("tbl_vld", 32'(vld), 32'd1);
                check("tbl_sample", sample, tbl[i-1].data);
                check("tbl_parity", 32'(par), 32'(tbl[i-1].par));
            end
        end

        // Three underflow pulses in RUN
        for (int i = 0; i < 3; i++) begin
            uf = 1'b1; step();
            uf = 1'b0; step();
        end

        // Disable: IDLE next clock, no read there, two in-flight samples still emerge
        check("rd_before_disable", 32'(rd), 32'd1);
        en = 1'b0;
        step();
        check("dis_rd", 32'(rd), 32'd0);
        check("dis_running", 32'(running), 32'd0);
        check("dis_vld1", 32'(vld), 32'd1);
        step();
        check("dis_vld2", 32'(vld), 32'd1);
        step();
        check("dis_vld_end", 32'(vld), 32'd0);
        uf = 1'b1; step();
        uf = 1'b0; step();
        check("uf_idle_ignored", 32'(uf_cnt), 32'd3);

        // Saturation: 20 pulses in RUN with a 4-bit counter
        srst = 1'b1; step(); srst = 1'b0; step();
        en = 1'b1;
        wait_running();
        uf = 1'b1;
        for (int i = 0; i < 20; i++) step();
        uf = 1'b0;
        step();
        check("uf_saturated", 32'(uf_cnt), 32'd15);

        // Reset one clock after a read drops the in-flight sample
        rate_div = 16'd3;
        wait_rd();
        step();
        srst = 1'b1;
        step();
        check("rstmid_vld", 32'(vld), 32'd0);
        check("rstmid_sample", sample, 32'd0);
        check("rstmid_parity", 32'(par), 32'd0);
        check("rstmid_rd", 32'(rd), 32'd0);
        check("rstmid_running", 32'(running), 32'd0);
        check("rstmid_uf", 32'(uf_cnt), 32'd0);
        check("rstmid_smp", 32'(smp_cnt), 32'd0);
        srst = 1'b0;
        step();

        // Randomized traffic against the model
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            srst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) rate_div = 16'($urandom_range(0, 5));
            dac_data = $urandom;
            uf = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
